alu_4b: RTL and testbench
=========================

ALU_4B -- requirements
Module: alu_4b

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 x  input  4  operand A, unsigned.
REQ-005 y  input  4  operand B, unsigned.
REQ-006 z  input  1  carry-in (ADD) / borrow-in (SUB); ignored for MUL/DIV.
REQ-007 p1  input  1  opcode MSB.
REQ-008 p2  input  1  opcode LSB.
REQ-009 m  output  8  full 8-bit result, registered.
REQ-010 e  output  4  low nibble / primary 4-bit result, registered.
REQ-011 c  output  1  carry / borrow / overflow / error flag, registered.
REQ-012 disp1op  output  7  seven-segment code of m[7:4], bit order {g,f,e,d,c,b,a}, active-high, registered.
REQ-013 disp2op  output  7  seven-segment code of m[3:0], same encoding, registered.

Function
REQ-014 Opcode {p1,p2}: 00 ADD, 01 SUB, 10 MUL, 11 DIV; inputs sampled every rising clk edge; results appear on all outputs exactly 1 cycle later; no handshake, a new operation is accepted every cycle.
REQ-015 ADD: {c,e} = x + y + z (5-bit); m = {3'b000, c, e}.
REQ-016 SUB: e = (x - y - z) mod 16; c = 1 when x < y + z (borrow); m = 8-bit two's-complement of x - y - z (sign-extended, e.g. 7-9 -> 8'hFE).
REQ-017 MUL: m = x * y (unsigned, 8-bit, never overflows); e = m[3:0]; c = 1 when m[7:4] != 0.
REQ-018 DIV (y != 0): e = x / y (quotient); m = {x % y, x / y}; c = 0.
REQ-019 DIV by zero (y == 0, any x including 0): m = 8'hFF, e = 4'hF, c = 1.
REQ-020 Hex-to-7-segment map (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-021 Display outputs are decoded from the next-state m value and registered in the same edge, so they are always consistent with m.
REQ-022 Opcode or operand change takes effect on the next edge only; no output glitching between edges.

Reset
REQ-023 rst_n low asynchronously forces m=8'h00, e=4'h0, c=0, disp1op=7'h00, disp2op=7'h00 (displays blank) regardless of clk.
REQ-024 rst_n deasserted: first rising edge loads the result of the currently applied inputs; reset mid-operation discards any pending result.

Configuration
REQ-025 Macro ALU_4B_DISP_EN defined: seven-segment decoders and registers per REQ-012/013/020/021 are compiled in.
REQ-026 ALU_4B_DISP_EN undefined: decoders and display registers omitted; disp1op and disp2op tied to 7'h00; m, e, c unaffected.

Verification
REQ-027 ADD x=10,y=5,z=0 -> next cycle m=8'h0F, e=F, c=0, disp1op=3F, disp2op=71.
REQ-028 ADD x=9,y=9,z=1 -> m=8'h13, e=3, c=1; SUB x=7,y=9,z=0 -> m=8'hFE, e=E, c=1, disp1op=71, disp2op=79.
REQ-029 MUL x=15,y=15 -> m=8'hE1, e=1, c=1, disp1op=79, disp2op=06; MUL x=2,y=1 -> m=8'h02, c=0.
REQ-030 DIV x=14,y=9 -> m=8'h51, e=1, c=0; DIV x=0,y=0 and x=15,y=0 -> m=8'hFF, e=F, c=1.
REQ-031 Assert rst_n low between clock edges while MUL 15*15 result is held -> outputs clear immediately to 0; release, apply ADD 1+1 -> m=8'h02 after first edge.
REQ-032 Build with and without ALU_4B_DISP_EN running REQ-027..030 -> identical m/e/c; displays 7'h00 when undefined.

Source files
------------

// File: rtl/alu_4b.sv
// Registered 4-bit ALU (ADD/SUB/MUL/DIV) with an 8-bit result and a flag.
// Define ALU_4B_DISP_EN to add registered seven-segment decodes of both result nibbles.
module alu_4b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       z,
    input  logic       p1,
    input  logic       p2,
    output logic [7:0] m,
    output logic [3:0] e,
    output logic       c,
    output logic [6:0] disp1op,
    output logic [6:0] disp2op
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    op_t        op;
    logic [4:0] sum5;
    logic [7:0] diff8;
    logic [7:0] prod8;
    logic [3:0] y_safe;
    logic [3:0] quo;
    logic [3:0] rem;
    logic [7:0] m_nxt;
    logic [3:0] e_nxt;
    logic       c_nxt;

    assign op = op_t'({p1, p2});

    // Operands are widened so the borrow shows up as the sign of the 8-bit difference.
    assign sum5   = {1'b0, x} + {1'b0, y} + {4'b0000, z};
    assign diff8  = {4'h0, x} - {4'h0, y} - {7'h00, z};
    assign prod8  = {4'h0, x} * {4'h0, y};
    // The divider never sees zero; the divide-by-zero result is substituted below.
    assign y_safe = (y == 4'h0) ? 4'h1 : y;
    assign quo    = x / y_safe;
    assign rem    = x % y_safe;

    always_comb begin
        m_nxt = 8'h00;
        e_nxt = 4'h0;
        c_nxt = 1'b0;
        case (op)
            OP_ADD: begin
                m_nxt = {3'b000, sum5};
                e_nxt = sum5[3:0];
                c_nxt = sum5[4];
            end
            OP_SUB: begin
                m_nxt = diff8;
                e_nxt = diff8[3:0];
                c_nxt = diff8[7];
            end
            OP_MUL: begin
                m_nxt = prod8;
                e_nxt = prod8[3:0];
                c_nxt = |prod8[7:4];
            end
            OP_DIV: begin
                if (y == 4'h0) begin
                    m_nxt = 8'hFF;
                    e_nxt = 4'hF;
                    c_nxt = 1'b1;
                end else begin
                    m_nxt = {rem, quo};
                    e_nxt = quo;
                    c_nxt = 1'b0;
                end
            end
            default: begin
                m_nxt = 8'h00;
                e_nxt = 4'h0;
                c_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= 8'h00;
            e <= 4'h0;
            c <= 1'b0;
        end else begin
            m <= m_nxt;
            e <= e_nxt;
            c <= c_nxt;
        end
    end

`ifdef ALU_4B_DISP_EN
    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    // Decoded from m_nxt so the displays load on the same edge as m.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp1op <= 7'h00;
            disp2op <= 7'h00;
        end else begin
            disp1op <= hex_to_seg(m_nxt[7:4]);
            disp2op <= hex_to_seg(m_nxt[3:0]);
        end
    end
`else
    assign disp1op = 7'h00;
    assign disp2op = 7'h00;
`endif

endmodule

// File: tb/tb_alu_4b.sv
module tb_alu_4b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] x = 4'h0;
    logic [3:0] y = 4'h0;
    logic       z = 1'b0;
    logic       p1 = 1'b0;
    logic       p2 = 1'b0;
    logic [7:0] m;
    logic [3:0] e;
    logic       c;
    logic [6:0] disp1op;
    logic [6:0] disp2op;

    alu_4b dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z), .p1(p1), .p2(p2),
        .m(m), .e(e), .c(c), .disp1op(disp1op), .disp2op(disp2op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] m;
        logic [3:0] e;
        logic       c;
        logic [6:0] d1;
        logic [6:0] d2;
        int         opc;
        int         xa;
        int         yb;
        int         zc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [6:0] seg_tab [16];

    initial begin
        seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
        seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
        seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
        seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference model on plain integers.
    function automatic exp_t model(input int opc, input int a, input int b, input int ci);
        exp_t r;
        int   res;
        r.opc = opc; r.xa = a; r.yb = b; r.zc = ci;
        r.c = 1'b0;
        case (opc)
            0: begin res = a + b + ci; r.c = (res > 15); end
            1: begin res = a - b - ci; r.c = (res < 0); end
            2: begin res = a * b; r.c = (res > 15); end
            default: begin
                if (b == 0) begin res = 255; r.c = 1'b1; end
                else res = (a % b) * 16 + (a / b);
            end
        endcase
        res = res & 255;
        r.m = 8'(res);
        r.e = (opc == 3 && b == 0) ? 4'hF : 4'(res % 16);
`ifdef ALU_4B_DISP_EN
        r.d1 = seg_tab[res / 16];
        r.d2 = seg_tab[res % 16];
`else
        r.d1 = 7'h00;
        r.d2 = 7'h00;
`endif
        return r;
    endfunction

    task automatic issue(input int opc, input int a, input int b, input int ci);
        @(negedge clk);
        {p1, p2} = 2'(opc);
        x = 4'(a);
        y = 4'(b);
        z = 1'(ci);
        exp_q.push_back(model(opc, a, b, ci));
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m"}, m, 0);
        check({tag, "_e"}, e, 0);
        check({tag, "_c"}, c, 0);
        check({tag, "_d1"}, disp1op, 0);
        check({tag, "_d2"}, disp2op, 0);
    endtask

    // Monitor: the DUT presents a result every cycle; compare whenever one is expected.
    initial begin
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                if (m !== ex.m || e !== ex.e || c !== ex.c || disp1op !== ex.d1 || disp2op !== ex.d2)
                    $display("op=%0d x=%0d y=%0d z=%0d", ex.opc, ex.xa, ex.yb, ex.zc);
                check("m", m, ex.m);
                check("e", e, ex.e);
                check("c", c, ex.c);
                check("disp1op", disp1op, ex.d1);
                check("disp2op", disp2op, ex.d2);
            end
        end
    end

    initial begin
        #3;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(0, 10, 5, 0);
        issue(0, 9, 9, 1);
        issue(1, 7, 9, 0);
        issue(2, 15, 15, 0);
        issue(2, 2, 1, 1);
        issue(3, 14, 9, 1);
        issue(3, 0, 0, 0);
        issue(3, 15, 0, 1);
        issue(0, 15, 15, 1);
        issue(1, 0, 15, 1);
        issue(1, 5, 5, 0);
        issue(1, 5, 4, 1);
        issue(2, 0, 15, 0);
        issue(3, 15, 1, 0);
        for (int i = 0; i < 300; i++)
            issue($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
        drain();

        // Asynchronous reset while a MUL 15*15 result is held.
        issue(2, 15, 15, 0);
        drain();
        check("held_m", m, 8'hE1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        {p1, p2} = 2'b00; x = 4'd1; y = 4'd1; z = 1'b0;
        exp_q.push_back(model(0, 1, 1, 0));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
